// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment panel: double-buffered
// frames committed at scan-frame boundaries, ghosting dead-time and flash blinking.
module seg_scan_ctrl #(
    parameter int DIGITS      = 5,
    parameter int SCAN_DIV    = 20000,
    parameter int FLASH_TICKS = 250,
    parameter int GUARD       = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*DIGITS-1:0]   frame_data,
    input  logic [2:0]            frame_mode,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    output logic [DIGITS-1:0]     seg_select,
    output logic [7:0]            seg_out,
    output logic [2:0]            flash_cnt,
    output logic                  frame_sync
);

    localparam int FW  = 8 * DIGITS;
    localparam int PW  = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
    localparam int FCW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam int GW  = (GUARD > 0)       ? $clog2(GUARD + 1)   : 1;
    localparam int IW  = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;

    typedef enum logic [2:0] {
        MODE_CONST = 3'd0,
        MODE_FLASH = 3'd1,
        MODE_BLANK = 3'd2
    } mode_t;

    logic [PW-1:0]  prescaler;
    logic [IW-1:0]  digit_idx;
    logic [GW-1:0]  guard_cnt;
    logic [FCW-1:0] flash_ctr;
    logic           flash_on;
    logic [FW-1:0]  active_frame;
    mode_t          active_mode;
    logic [FW-1:0]  pending_frame;
    mode_t          pending_mode;
    logic           pending_full;

    logic           tick;
    logic           wrap;
    logic           commit;
    logic           flash_restart;
    logic           flash_wrap;
    mode_t          offer_mode;
    logic [IW-1:0]  idx_nxt;
    logic [GW-1:0]  guard_nxt;
    logic [FCW-1:0] ctr_nxt;
    logic           phase_nxt;
    logic [2:0]     cnt_nxt;
    logic [FW-1:0]  frame_nxt;
    mode_t          mode_nxt;
    logic [7:0]     digit_byte;
    logic [DIGITS-1:0] sel_nxt;
    logic [7:0]     seg_nxt;

    assign frame_ready = !pending_full;

    assign tick          = (prescaler == PW'(SCAN_DIV - 1));
    assign wrap          = tick && (digit_idx == IW'(DIGITS - 1));
    assign commit        = wrap && pending_full;
    assign flash_restart = commit && (pending_mode == MODE_FLASH) && (active_mode != MODE_FLASH);
    assign flash_wrap    = tick && (flash_ctr == FCW'(FLASH_TICKS - 1));
    assign frame_nxt     = commit ? pending_frame : active_frame;
    assign mode_nxt      = commit ? pending_mode  : active_mode;

    // Modes 3..7 are folded into blank when the frame is accepted.
    always_comb begin
        case (frame_mode)
            3'd0:    offer_mode = MODE_CONST;
            3'd1:    offer_mode = MODE_FLASH;
            default: offer_mode = MODE_BLANK;
        endcase
    end

    always_comb begin
        idx_nxt   = digit_idx;
        guard_nxt = guard_cnt;
        if (tick) begin
            idx_nxt   = wrap ? '0 : digit_idx + IW'(1);
            guard_nxt = GW'(GUARD);
        end else if (guard_cnt != '0) begin
            guard_nxt = guard_cnt - GW'(1);
        end
    end

    // A restart into flash mode wins over any toggle or increment on the same tick.
    always_comb begin
        ctr_nxt   = flash_ctr;
        phase_nxt = flash_on;
        cnt_nxt   = flash_cnt;
        if (flash_restart) begin
            ctr_nxt   = '0;
            phase_nxt = 1'b1;
            cnt_nxt   = 3'd0;
        end else if (tick) begin
            ctr_nxt = flash_wrap ? '0 : flash_ctr + FCW'(1);
            if (flash_wrap) begin
                phase_nxt = !flash_on;
                if (!flash_on && mode_nxt == MODE_FLASH && flash_cnt != 3'd7)
                    cnt_nxt = flash_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        digit_byte = 8'h00;
        sel_nxt    = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx_nxt == IW'(d)) begin
                digit_byte = frame_nxt[8*(DIGITS-1-d) +: 8];
                sel_nxt[d] = 1'b1;
            end
        end
    end

    // Segments are registered from next-state values so they line up with seg_select;
    // the step edge itself is therefore already blanked by the freshly loaded guard.
    always_comb begin
        seg_nxt = 8'h00;
        if (guard_nxt == '0) begin
            case (mode_nxt)
                MODE_CONST: seg_nxt = digit_byte;
                MODE_FLASH: seg_nxt = phase_nxt ? digit_byte : 8'h00;
                default:    seg_nxt = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler     <= '0;
            digit_idx     <= '0;
            guard_cnt     <= '0;
            flash_ctr     <= '0;
            flash_on      <= 1'b1;
            flash_cnt     <= 3'd0;
            active_frame  <= '0;
            active_mode   <= MODE_BLANK;
            pending_frame <= '0;
            pending_mode  <= MODE_BLANK;
            pending_full  <= 1'b0;
            seg_select    <= DIGITS'(1);
            seg_out       <= 8'h00;
            frame_sync    <= 1'b0;
        end else begin
            prescaler    <= tick ? '0 : prescaler + PW'(1);
            digit_idx    <= idx_nxt;
            guard_cnt    <= guard_nxt;
            flash_ctr    <= ctr_nxt;
            flash_on     <= phase_nxt;
            flash_cnt    <= cnt_nxt;
            active_frame <= frame_nxt;
            active_mode  <= mode_nxt;
            seg_select   <= sel_nxt;
            seg_out      <= seg_nxt;
            frame_sync   <= commit;
            if (commit) begin
                pending_full <= 1'b0;
            end else if (frame_valid && !pending_full) begin
                pending_frame <= frame_data;
                pending_mode  <= offer_mode;
                pending_full  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a cycle table for scan/handshake/commit plus
// hand-written sequences for flash counting, re-entry, odd modes and mid-run reset.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] frame_data;
    logic [2:0]  frame_mode;
    logic        frame_valid;
    logic        frame_ready;
    logic [4:0]  seg_select;
    logic [7:0]  seg_out;
    logic [2:0]  flash_cnt;
    logic        frame_sync;

    seg_scan_ctrl #(
        .DIGITS(DIGITS), .SCAN_DIV(4), .FLASH_TICKS(3), .GUARD(1)
    ) dut (
        .clk(clk), .reset(reset),
        .frame_data(frame_data), .frame_mode(frame_mode), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .seg_select(seg_select), .seg_out(seg_out),
        .flash_cnt(flash_cnt), .frame_sync(frame_sync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [39:0] data;
        logic [2:0]  mode;
        int          n;
        logic [4:0]  sel;
        logic [7:0]  seg;
        logic        rdy;
        logic        sync;
        logic [2:0]  fcnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [39:0] F1   = 40'h3F_06_5B_4F_66;
    localparam logic [39:0] F2   = 40'hFF_FF_FF_FF_FF;
    localparam logic [39:0] F3   = 40'h01_02_04_08_10;
    localparam logic [39:0] FRST = 40'hAA_AA_AA_AA_AA;

    task automatic add(input logic rst, input logic valid, input logic [39:0] data,
                       input logic [2:0] mode, input int n, input logic [4:0] sel,
                       input logic [7:0] seg, input logic rdy, input logic sync,
                       input logic [2:0] fcnt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.data = data; v.mode = mode; v.n = n;
        v.sel = sel; v.seg = seg; v.rdy = rdy; v.sync = sync; v.fcnt = fcnt;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        reset       = v.rst;
        frame_valid = v.valid;
        frame_data  = v.data;
        frame_mode  = v.mode;
        repeat (v.n) step();
        checkOutput($sformatf("vec%0d.sel", idx),   40'(seg_select),  40'(v.sel));
        checkOutput($sformatf("vec%0d.seg", idx),   40'(seg_out),     40'(v.seg));
        checkOutput($sformatf("vec%0d.ready", idx), 40'(frame_ready), 40'(v.rdy));
        checkOutput($sformatf("vec%0d.sync", idx),  40'(frame_sync),  40'(v.sync));
        checkOutput($sformatf("vec%0d.fcnt", idx),  40'(flash_cnt),   40'(v.fcnt));
    endtask

    task automatic offer(input string name, input logic [39:0] d, input logic [2:0] m);
        checkOutput({name, ".ready_before"}, 40'(frame_ready), 40'd1);
        frame_valid = 1'b1;
        frame_data  = d;
        frame_mode  = m;
        step();
        frame_valid = 1'b0;
    endtask

    task automatic waitSync(input string name);
        int cnt;
        cnt = 0;
        while (frame_sync !== 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        checkOutput({name, ".sync_seen"}, 40'(frame_sync), 40'd1);
    endtask

    initial begin
        logic [39:0] shifted;
        logic [7:0]  exp_seg;
        int          exp_cnt;
        logic        seen_bad;
        int          cnt;

        reset = 1'b1; frame_valid = 1'b0; frame_data = '0; frame_mode = 3'd0;

        // Cycle k is the state after the (3+k)-th edge; reset is held for edges 1..3.
        //   rst valid data mode  n   sel       seg    rdy   sync  fcnt
        add(1, 0, '0, 3'd0, 1, 5'b00001, 8'h00, 1'b1, 1'b0, 3'd0);
        add(1, 0, '0, 3'd0, 2, 5'b00001, 8'h00, 1'b1, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 3, 5'b00001, 8'h00, 1'b1, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 1, 5'b00010, 8'h00, 1'b1, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 2, 5'b00010, 8'h00, 1'b1, 1'b0, 3'd0);
        add(0, 1, F1, 3'd0, 1, 5'b00010, 8'h00, 1'b0, 1'b0, 3'd0);
        add(0, 1, F2, 3'd0, 1, 5'b00100, 8'h00, 1'b0, 1'b0, 3'd0);
        add(0, 1, F2, 3'd0, 1, 5'b00100, 8'h00, 1'b0, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 3, 5'b01000, 8'h00, 1'b0, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 6, 5'b10000, 8'h00, 1'b0, 1'b0, 3'd0);
        add(0, 1, F2, 3'd0, 1, 5'b10000, 8'h00, 1'b0, 1'b0, 3'd0);
        add(0, 1, F2, 3'd0, 1, 5'b00001, 8'h00, 1'b1, 1'b1, 3'd0);
        add(0, 0, '0, 3'd0, 1, 5'b00001, 8'h3F, 1'b1, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 2, 5'b00001, 8'h3F, 1'b1, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 1, 5'b00010, 8'h00, 1'b1, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 1, 5'b00010, 8'h06, 1'b1, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 4, 5'b00100, 8'h5B, 1'b1, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 4, 5'b01000, 8'h4F, 1'b1, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 3, 5'b10000, 8'h00, 1'b1, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 1, 5'b10000, 8'h66, 1'b1, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 2, 5'b10000, 8'h66, 1'b1, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 1, 5'b00001, 8'h00, 1'b1, 1'b0, 3'd0);
        add(0, 0, '0, 3'd0, 1, 5'b00001, 8'h3F, 1'b1, 1'b0, 3'd0);

        for (int i = 0; i < tbl.size(); i++)
            applyStimulus(tbl[i], i);

        // Flash: on for 3 digit steps, off for 3, count +1 every 6 steps, saturate at 7.
        offer("flash", F3, 3'd1);
        waitSync("flash");
        checkOutput("flash.fcnt_clear", 40'(flash_cnt), 40'd0);
        step();
        for (int j = 0; j < 54; j++) begin
            shifted = F3 >> (8 * (4 - (j % 5)));
            exp_seg = (((j / 3) % 2) == 0) ? shifted[7:0] : 8'h00;
            exp_cnt = ((j / 6) > 7) ? 7 : (j / 6);
            checkOutput($sformatf("flash.seg_step%0d", j), 40'(seg_out), 40'(exp_seg));
            checkOutput($sformatf("flash.cnt_step%0d", j), 40'(flash_cnt), 40'(exp_cnt));
            repeat (4) step();
        end

        // Constant mode keeps the count; re-entering flash clears it.
        offer("const", F3, 3'd0);
        waitSync("const");
        checkOutput("const.fcnt_hold", 40'(flash_cnt), 40'd7);
        step();
        checkOutput("const.seg_digit0", 40'(seg_out), 40'h01);
        repeat (40) step();
        checkOutput("const.fcnt_hold_late", 40'(flash_cnt), 40'd7);

        offer("reentry", F3, 3'd1);
        waitSync("reentry");
        checkOutput("reentry.fcnt_clear", 40'(flash_cnt), 40'd0);
        step();
        checkOutput("reentry.seg_on", 40'(seg_out), 40'h01);

        // Mode 5 must behave as blank for a whole scan frame.
        offer("mode5", F3, 3'd5);
        waitSync("mode5");
        seen_bad = 1'b0;
        repeat (20) begin
            step();
            if (seg_out !== 8'h00) seen_bad = 1'b1;
        end
        checkOutput("mode5.blank", 40'(seen_bad), 40'd0);

        // Reset while a frame is pending and digit 3 is being scanned.
        offer("rst_pending", FRST, 3'd0);
        cnt = 0;
        while (seg_select !== 5'b01000 && cnt < 30) begin
            step();
            cnt++;
        end
        checkOutput("rst.reached_digit3", 40'(seg_select), 40'(5'b01000));
        checkOutput("rst.pending_full", 40'(frame_ready), 40'd0);
        reset = 1'b1;
        step();
        checkOutput("rst.sel", 40'(seg_select), 40'(5'b00001));
        checkOutput("rst.ready", 40'(frame_ready), 40'd1);
        checkOutput("rst.seg", 40'(seg_out), 40'h00);
        checkOutput("rst.fcnt", 40'(flash_cnt), 40'd0);
        reset = 1'b0;
        seen_bad = 1'b0;
        repeat (30) begin
            step();
            if (seg_out !== 8'h00 || frame_sync !== 1'b0) seen_bad = 1'b1;
        end
        checkOutput("rst.pending_discarded", 40'(seen_bad), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
